// File: rtl/dp_pkg.sv
// Shared definitions for the JTAG debug data register family.
// Holds the status-field width, the status bit positions inside the shift
// register, and the TAP strobe bundle used inside the data register.
package dp_pkg;

    // Two status bits sit below the payload in every data register.
    localparam int DP_STAT_W = 2;
    localparam int DP_BUSY_B = 0;   // captured upd_valid; shifted-in 1 means "clear"
    localparam int DP_OVR_B  = 1;   // captured overrun flag

    // TAP strobes as seen in the iclk domain.
    typedef struct packed {
        logic capture;
        logic shift;
        logic update;
        logic clk;
    } dp_dr_strb_t;

endpackage : dp_pkg

// File: rtl/dp_one_drc.sv
// Single data-register shift cell: a capture mux in front of one flop.
// Ports:
//   clk_i      - internal clock
//   rst_ni     - asynchronous active-low reset
//   cap_en_i   - load pd_i (has priority over shift)
//   shift_en_i - load sd_i from the upstream cell
//   pd_i       - parallel capture bit
//   sd_i       - serial input (next-higher cell, or TDI for the top cell)
//   sd_o       - serial output (the stored bit)
module dp_one_drc (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic cap_en_i,
    input  logic shift_en_i,
    input  logic pd_i,
    input  logic sd_i,
    output logic sd_o
);

    logic bit_q;
    logic bit_d;

    always_comb begin
        bit_d = bit_q;
        if (cap_en_i) begin
            bit_d = pd_i;
        end else if (shift_en_i) begin
            bit_d = sd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_q <= 1'b0;
        end else begin
            bit_q <= bit_d;
        end
    end

    assign sd_o = bit_q;

endmodule : dp_one_drc

// File: rtl/dp_dr_hs.sv
// JTAG debug data register with a valid/ready update port.
// Captures {pdi, overrun, upd_valid}, shifts LSB-first through sdi/sdo, and on
// Update-DR hands the shifted payload to a system-side consumer.
// Ports:
//   iclk, iresetn              - clock, asynchronous active-low reset
//   select                     - this DR is addressed by the current IR
//   pdi                        - parallel capture data
//   pdo, upd_valid, upd_ready  - update word and its handshake
//   sdi, sdo                   - serial in (TDI) / serial out (TDO = sr[0])
//   capture_dr, shift_dr, update_dr, clk_dr - TAP strobes in the iclk domain
module dp_dr_hs
    import dp_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] UPD_r = '0
) (
    input  logic             iclk,
    input  logic             iresetn,
    input  logic             select,
    input  logic [WIDTH-1:0] pdi,
    output logic [WIDTH-1:0] pdo,
    output logic             upd_valid,
    input  logic             upd_ready,
    input  logic             sdi,
    output logic             sdo,
    input  logic             capture_dr,
    input  logic             shift_dr,
    input  logic             update_dr,
    input  logic             clk_dr
);

    localparam int SR_W = WIDTH + DP_STAT_W;

    dp_dr_strb_t strb;
    logic        cap_en;
    logic        shift_en;
    logic        upd_en;

    logic [SR_W-1:0]  sr_q;
    logic [SR_W-1:0]  cap_data;
    logic [SR_W-1:0]  sd_in;

    logic [WIDTH-1:0] pdo_q;
    logic [WIDTH-1:0] pdo_d;
    logic             upd_valid_q;
    logic             upd_valid_d;
    logic             ovr_q;
    logic             ovr_d;
    logic             xfer;

    assign strb.capture = capture_dr;
    assign strb.shift   = shift_dr;
    assign strb.update  = update_dr;
    assign strb.clk     = clk_dr;

    // Capture beats shift beats update; an update in a cycle where the shift
    // register is also being loaded is discarded.
    assign cap_en   = select & strb.clk & strb.capture;
    assign shift_en = select & strb.clk & strb.shift & ~cap_en;
    assign upd_en   = select & strb.update & ~cap_en & ~shift_en;

    assign cap_data = {pdi, ovr_q, upd_valid_q};

    // Cell gi takes its serial input from cell gi+1; the top cell takes TDI.
    for (genvar gi = 0; gi < SR_W; gi++) begin : g_cell
        if (gi == SR_W - 1) begin : g_top
            assign sd_in[gi] = sdi;
        end else begin : g_mid
            assign sd_in[gi] = sr_q[gi + 1];
        end

        dp_one_drc u_cell (
            .clk_i      (iclk),
            .rst_ni     (iresetn),
            .cap_en_i   (cap_en),
            .shift_en_i (shift_en),
            .pd_i       (cap_data[gi]),
            .sd_i       (sd_in[gi]),
            .sd_o       (sr_q[gi])
        );
    end

    assign xfer = upd_valid_q & upd_ready;

    always_comb begin
        pdo_d       = pdo_q;
        upd_valid_d = upd_valid_q & ~xfer;
        ovr_d       = ovr_q;
        if (upd_en) begin
            if (sr_q[DP_BUSY_B]) begin
                ovr_d = 1'b0;
            end else if (!upd_valid_q || xfer) begin
                // Slot is free, or is being vacated this very cycle.
                pdo_d       = sr_q[SR_W-1:DP_STAT_W];
                upd_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge iclk or negedge iresetn) begin
        if (!iresetn) begin
            pdo_q       <= UPD_r;
            upd_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            pdo_q       <= pdo_d;
            upd_valid_q <= upd_valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign pdo       = pdo_q;
    assign upd_valid = upd_valid_q;
    assign sdo       = sr_q[DP_BUSY_B];

endmodule : dp_dr_hs

// File: tb/tb_dp_dr_hs.sv
// Self-checking bench for dp_dr_hs with WIDTH=8.
module tb_dp_dr_hs;

    localparam int         W       = 8;
    localparam logic [7:0] RST_PDO = 8'h5A;

    logic         iclk;
    logic         iresetn;
    logic         select;
    logic [W-1:0] pdi;
    logic [W-1:0] pdo;
    logic         upd_valid;
    logic         upd_ready;
    logic         sdi;
    logic         sdo;
    logic         capture_dr;
    logic         shift_dr;
    logic         update_dr;
    logic         clk_dr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the register contents as the spec describes them.
    logic [W+1:0] m_sr;
    logic [W-1:0] m_pdo;
    logic         m_valid;
    logic         m_ovr;

    dp_dr_hs #(.WIDTH(W), .UPD_r(RST_PDO)) dut (
        .iclk       (iclk),
        .iresetn    (iresetn),
        .select     (select),
        .pdi        (pdi),
        .pdo        (pdo),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .sdi        (sdi),
        .sdo        (sdo),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .clk_dr     (clk_dr)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic model_reset();
        m_sr    = '0;
        m_pdo   = RST_PDO;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // Advance one clock; the model applies the spec rules to the inputs
    // that were present at the edge. Returns 1 ns after the edge.
    task automatic tick();
        bit           cap, sh, upd, xfer;
        logic [W+1:0] n_sr;
        logic [W-1:0] n_pdo;
        logic         n_valid, n_ovr;
        cap  = select && clk_dr && capture_dr;
        sh   = select && clk_dr && shift_dr && !cap;
        upd  = select && update_dr && !cap && !sh;
        xfer = m_valid && upd_ready;
        n_sr = m_sr;
        if (cap)     n_sr = {pdi, m_ovr, m_valid};
        else if (sh) n_sr = (m_sr >> 1) | ((W+2)'(sdi) << (W+1));
        n_pdo   = m_pdo;
        n_valid = m_valid && !xfer;
        n_ovr   = m_ovr;
        if (upd) begin
            if (m_sr[0])                 n_ovr = 1'b0;
            else if (!m_valid || xfer) begin
                n_pdo   = m_sr[W+1:2];
                n_valid = 1'b1;
            end else                     n_ovr = 1'b1;
        end
        @(posedge iclk);
        #1;
        m_sr = n_sr; m_pdo = n_pdo; m_valid = n_valid; m_ovr = n_ovr;
    endtask

    task automatic idle_inputs();
        capture_dr = 0; shift_dr = 0; update_dr = 0; clk_dr = 0;
    endtask

    task automatic do_capture(input logic [W-1:0] d);
        pdi = d; clk_dr = 1; capture_dr = 1;
        tick();
        idle_inputs();
    endtask

    task automatic do_shift(input logic b);
        sdi = b; clk_dr = 1; shift_dr = 1;
        tick();
        idle_inputs();
    endtask

    task automatic shift_word(input logic [W+1:0] v);
        for (int i = 0; i < W + 2; i++) do_shift(v[i]);
    endtask

    task automatic do_update();
        update_dr = 1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        iresetn = 0; select = 1; pdi = '0; upd_ready = 0; sdi = 0;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge iclk);
        #1;
        iresetn = 1;
        tick(); tick();
        n_tests++;
        if ({pdo, upd_valid, sdo} !== {RST_PDO, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got pdo=%h valid=%b sdo=%b, expected pdo=%h valid=0 sdo=0",
                     pdo, upd_valid, sdo, RST_PDO);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_capture_shift();
        logic [9:0] seq;
        seq = 10'b1010010100;   // sr after capture of A5 with both flags 0
        do_capture(8'hA5);
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (sdo !== seq[i]) begin
                n_fail++;
                $display("FAIL capture_shift bit%0d: got sdo=%b, expected %b", i, sdo, seq[i]);
            end
            do_shift(1'b0);
        end
        $display("[TB] capture A5 and shift-out checked");
    endtask

    task automatic test_update_handshake();
        upd_ready = 0;
        shift_word({8'h3C, 2'b00});
        do_update();
        n_tests++;
        if ({pdo, upd_valid} !== {8'h3C, 1'b1}) begin
            n_fail++;
            $display("FAIL update: got pdo=%h valid=%b, expected pdo=3c valid=1", pdo, upd_valid);
        end
        upd_ready = 1;
        tick();
        upd_ready = 0;
        n_tests++;
        if (upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL handshake_drop: got valid=%b, expected 0", upd_valid);
        end
        $display("[TB] update 3c and handshake checked");
    endtask

    task automatic test_overrun();
        upd_ready = 0;
        shift_word({8'h3C, 2'b00});
        do_update();
        shift_word({8'h77, 2'b00});
        do_update();
        n_tests++;
        if ({pdo, upd_valid} !== {8'h3C, 1'b1}) begin
            n_fail++;
            $display("FAIL overrun_hold: got pdo=%h valid=%b, expected pdo=3c valid=1", pdo, upd_valid);
        end
        do_capture(8'h00);
        n_tests++;
        if (sdo !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_busy: got sr0=%b, expected 1", sdo);
        end
        do_shift(1'b0);
        n_tests++;
        if (sdo !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_flag: got sr1=%b, expected 1", sdo);
        end
        $display("[TB] overrun on 77 checked");
    endtask

    task automatic test_clear();
        upd_ready = 0;
        shift_word({8'hFF, 2'b01});
        do_update();
        n_tests++;
        if ({pdo, upd_valid} !== {8'h3C, 1'b1}) begin
            n_fail++;
            $display("FAIL clear_hold: got pdo=%h valid=%b, expected pdo=3c valid=1", pdo, upd_valid);
        end
        do_capture(8'h00);
        do_shift(1'b0);
        n_tests++;
        if (sdo !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_flag: got overrun=%b, expected 0", sdo);
        end
        $display("[TB] clear command checked");
    endtask

    task automatic test_back_to_back();
        // A word is still pending (3C); accept and replace it in one cycle.
        shift_word({8'h96, 2'b00});
        upd_ready = 1;
        do_update();
        n_tests++;
        if ({pdo, upd_valid} !== {8'h96, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_accept: got pdo=%h valid=%b, expected pdo=96 valid=1", pdo, upd_valid);
        end
        tick();
        n_tests++;
        if (upd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drop: got valid=%b, expected 0", upd_valid);
        end
        do_capture(8'h00);
        do_shift(1'b0);
        n_tests++;
        if (sdo !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_overrun: got overrun=%b, expected 0", sdo);
        end
        // Ready held high: each update is a single-cycle valid pulse.
        shift_word({8'hC3, 2'b00});
        do_update();
        n_tests++;
        if ({pdo, upd_valid} !== {8'hC3, 1'b1}) begin
            n_fail++;
            $display("FAIL pulse_high: got pdo=%h valid=%b, expected pdo=c3 valid=1", pdo, upd_valid);
        end
        tick();
        n_tests++;
        if ({pdo, upd_valid} !== {8'hC3, 1'b0}) begin
            n_fail++;
            $display("FAIL pulse_low: got pdo=%h valid=%b, expected pdo=c3 valid=0", pdo, upd_valid);
        end
        upd_ready = 0;
        $display("[TB] back-to-back and ready-held pulses checked");
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 600; c++) begin
            select     = ($urandom_range(0, 7) != 0);
            clk_dr     = $urandom_range(0, 1);
            capture_dr = ($urandom_range(0, 7) == 0);
            shift_dr   = $urandom_range(0, 1);
            update_dr  = ($urandom_range(0, 4) == 0);
            upd_ready  = ($urandom_range(0, 2) == 0);
            sdi        = $urandom_range(0, 1);
            pdi        = W'($urandom);
            tick();
            n_tests++;
            if ({pdo, upd_valid, sdo} !== {m_pdo, m_valid, m_sr[0]}) begin
                n_fail++;
                errs++;
                if (errs <= 5)
                    $display("FAIL random cyc%0d: got pdo=%h valid=%b sdo=%b, expected pdo=%h valid=%b sdo=%b",
                             c, pdo, upd_valid, sdo, m_pdo, m_valid, m_sr[0]);
            end
        end
        idle_inputs();
        select = 1; upd_ready = 0;
        $display("[TB] 600 random cycles against model");
    endtask

    task automatic test_async_reset();
        upd_ready = 1;
        tick();                      // drain anything pending
        upd_ready = 0;
        shift_word({8'hE1, 2'b00});
        do_update();
        do_capture(8'hFF);           // sr[0] now holds valid=1
        do_shift(1'b1);
        clk_dr = 1; shift_dr = 1; sdi = 1;
        @(posedge iclk);
        #3;
        iresetn = 0;
        #1;
        n_tests++;
        if ({pdo, upd_valid, sdo} !== {RST_PDO, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset: got pdo=%h valid=%b sdo=%b, expected pdo=%h valid=0 sdo=0",
                     pdo, upd_valid, sdo, RST_PDO);
        end
        idle_inputs();
        model_reset();
        @(negedge iclk);
        iresetn = 1;
        do_capture(8'h00);
        do_shift(1'b0);
        n_tests++;
        if (sdo !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_overrun: got overrun=%b, expected 0", sdo);
        end
        $display("[TB] asynchronous reset mid-shift checked");
    endtask

    initial begin
        test_reset();
        test_capture_shift();
        test_update_handshake();
        test_overrun();
        test_clear();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dp_dr_hs
